gcd_dispatch: RTL and testbench

- Front-end/back-end sequencer for the small GCD core.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches one job at a time into the core with a single-cycle start pulse and waits for a trustworthy done.
- Returns each result, with an error flag, on a valid/ready output stream in arrival order.
- Shields consumers from core quirks: stale done after start, pending never clearing, non-termination when a==0 and b!=0.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_dispatch_fifo.sv | 52 +++++
 rtl/gcd_dispatch.sv | 138 +++++++++++++
 tb/tb_gcd_dispatch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD dispatch sequencer: operand pair and FSM state.
package gcd_pkg;

  localparam int W = 15;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } gcd_pair_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } gcd_state_t;

endpackage

// File: rtl/gcd_dispatch_fifo.sv
// Operand-pair FIFO: power-of-two depth, pointers wrap naturally, occupancy counter.
module gcd_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [DW-1:0]          wdata_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gcd_dispatch.sv
// GCD core sequencer: buffers operand pairs, runs one core job at a time,
// masks stale done / non-termination, and returns ordered results with an error flag.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int W       = gcd_pkg::W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  output logic                   core_start,
  output logic [W-1:0]           core_a,
  output logic [W-1:0]           core_b,
  input  logic [W-1:0]           core_res,
  input  logic                   core_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_res,
  output logic                   out_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  gcd_pair_t  wr_pair, head;
  logic       full, empty, push, dispatch;

  gcd_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  core_a_q, core_a_d, core_b_q, core_b_d;
  logic [W-1:0]  out_res_q, out_res_d;
  logic          out_valid_q, out_valid_d, out_err_q, out_err_d;

  assign wr_pair = gcd_pair_t'({in_a, in_b});
  assign push    = in_valid & ~full;

  // A new job may only leave the FIFO once the output slot is free this cycle.
  assign dispatch = (state_q == IDLE) & ~empty & (~out_valid_q | out_ready);

  gcd_dispatch_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(gcd_pair_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (wr_pair),
    .pop_i   (dispatch),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_res_d   = out_res_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (dispatch) begin
          // a==0 would never terminate in the core; gcd(0,b)=b is answered here.
          if (head.a == '0) begin
            out_valid_d = 1'b1;
            out_res_d   = head.b;
            out_err_d   = 1'b0;
          end else begin
            core_a_d = head.a;
            core_b_d = head.b;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = ARM;
      ARM: begin
        // core_done still reflects the previous job here.
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          out_valid_d = 1'b1;
          out_res_d   = core_res;
          out_err_d   = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          out_valid_d = 1'b1;
          out_res_d   = '0;
          out_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready   = ~full;
  assign core_start = (state_q == ISSUE);
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;
  assign out_err    = out_err_q;
  assign busy       = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a subtractive GCD core model that leaves
// core_done stale for one cycle after start and never terminates on a==0.
module tb_gcd_dispatch;
  localparam int W = 15, DEPTH = 4, TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, core_start, core_done;
  logic out_valid, out_ready, out_err, busy;
  logic [W-1:0] in_a, in_b, core_a, core_b, core_res, out_res;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  gcd_dispatch #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_a(core_a),
    .core_b(core_b), .core_res(core_res), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_err(out_err), .busy(busy), .fifo_count(fifo_count)
  );

  // Core model: done is only rewritten once the core starts stepping.
  logic [W-1:0] cx, cy;
  logic cbusy, cdone, kill;
  int   n_start = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx <= '0; cy <= '0; cbusy <= 1'b0; cdone <= 1'b0;
    end else if (core_start) begin
      cx <= core_a; cy <= core_b; cbusy <= 1'b1;
    end else if (cbusy) begin
      if (cy == '0) begin
        cdone <= 1'b1; cbusy <= 1'b0;
      end else begin
        cdone <= 1'b0;
        if (cx > cy) cx <= cx - cy;
        else         cy <= cy - cx;
      end
    end
  end
  assign core_res  = cx;
  assign core_done = cdone & ~kill;

  always @(posedge clk) if (reset && core_start) n_start <= n_start + 1;

  int n_asrt = 0, n_fail = 0;
  int lat, s0, ng, cyc;
  logic accept5, errs;
  logic [W-1:0] got [6];
  logic [W-1:0] exp_res [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns the cycle offset from acceptance at which out_valid appears (bounded).
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; kill = 1'b0;
    #12;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) reset = 1'b1;
    tick();

    // gcd(12,18)=6 via core, 3 subtraction steps
    s0 = n_start;
    push(15'd12, 15'd18);
    wait_out(lat);
    chk("core_lat", lat, 8);
    chk("core_res", out_res, 6);
    chk("core_err", out_err, 0);
    chk("core_starts", n_start - s0, 1);
    tick(); tick(); tick();
    chk("hold_valid", out_valid, 1);
    chk("hold_res", out_res, 6);
    take();
    chk("handshake_clear", out_valid, 0);
    chk("idle_busy", busy, 0);

    // b==0: minimum core latency; stale done in ARM must be ignored
    push(15'd7, 15'd0);
    wait_out(lat);
    chk("b0_lat", lat, 5);
    chk("b0_res", out_res, 7);
    take();

    // a==0 bypass
    s0 = n_start;
    push(15'd0, 15'd9);
    chk("byp_c1_valid", out_valid, 0);
    tick();
    chk("byp_c2_valid", out_valid, 1);
    chk("byp_res", out_res, 9);
    chk("byp_err", out_err, 0);
    chk("byp_starts", n_start - s0, 0);
    take();

    // Fill FIFO behind a held result, then drain in order
    push(15'd0, 15'd1);
    tick();
    chk("held_valid", out_valid, 1);
    push(15'd8, 15'd12);
    push(15'd0, 15'd3);
    push(15'd9, 15'd6);
    push(15'd5, 15'd0);
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_busy", busy, 1);
    in_a = 15'd14; in_b = 15'd21; in_valid = 1'b1;
    tick();
    chk("full_no_accept", fifo_count, 4);
    exp_res[0] = 15'd1; exp_res[1] = 15'd4; exp_res[2] = 15'd3;
    exp_res[3] = 15'd3; exp_res[4] = 15'd5; exp_res[5] = 15'd7;
    out_ready = 1'b1; ng = 0; cyc = 0; errs = 1'b0;
    while (ng < 6 && cyc < 200) begin
      if (out_valid) begin
        got[ng] = out_res;
        errs = errs | out_err;
        ng++;
      end
      accept5 = in_valid && in_ready;
      tick();
      cyc++;
      if (accept5) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("drain_count", ng, 6);
    chk("drain_errs", errs, 0);
    for (int i = 0; i < 6; i++)
      if (i < ng) chk($sformatf("drain_res%0d", i), got[i], exp_res[i]);
    chk("drain_fifo_empty", fifo_count, 0);

    // Timeout: done masked, job aborts after TIMEOUT WAIT cycles
    kill = 1'b1;
    push(15'd5, 15'd3);
    wait_out(lat);
    chk("to_lat", lat, 20);
    chk("to_err", out_err, 1);
    chk("to_res", out_res, 0);
    take();
    kill = 1'b0;
    push(15'd9, 15'd6);
    wait_out(lat);
    chk("after_to_lat", lat, 8);
    chk("after_to_res", out_res, 3);
    chk("after_to_err", out_err, 0);
    take();

    // Asynchronous reset in WAIT with a queued entry
    push(15'd12, 15'd18);
    push(15'd3, 15'd3);
    tick(); tick();
    chk("pre_rst_count", fifo_count, 1);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_core_a", core_a, 12);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_core_start", core_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_core_a", core_a, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    push(15'd6, 15'd4);
    wait_out(lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_res", out_res, 2);
    take();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
